nibble_cascade_comparator: RTL
==============================

NIBBLE_CASCADE_COMPARATOR -- requirements
Module: nibble_cascade_comparator

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand length in 4-bit nibbles; legal range 2..16.
REQ-002 SHALL have parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of the in-progress operand pair.
REQ-006 SHALL have port in_valid  input  1  nibble pair on in_a/in_b is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a nibble pair this cycle.
REQ-008 SHALL have ports in_a and in_b  input  4 each  current nibble of operands A and B, MSB nibble first.
REQ-009 SHALL have port out_valid  output  1  compare result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have ports out_gt, out_eq, out_lt  output  1 each  A>B, A==B, A<B; one-hot when out_valid.
REQ-012 SHALL have port out_busy  output  1  at least one nibble of the current pair has been accepted.

Function
REQ-013 SHALL accept a beat when in_valid and in_ready are both high; each operand pair is exactly NIBBLES beats.
REQ-014 SHALL track the beat index with a counter 0..NIBBLES-1 that wraps to 0 after the last beat.
REQ-015 SHALL hold cascade state {gt,eq,lt}; it is {0,1,0} at the start of every pair.
REQ-016 SHALL, while eq is 1, set gt if nibble A>B, set lt if A<B, and keep eq if A==B; the compare is 4-bit unsigned.
REQ-017 SHALL, once gt or lt is set, ignore later nibbles of the same pair; those beats are still consumed.
REQ-018 SHALL, when SIGNED=1, invert bit 3 of both nibbles on beat 0 only, before the compare.
REQ-019 SHALL use two states, COLLECT and HOLD; reset state is COLLECT.
REQ-020 SHALL go COLLECT->HOLD on acceptance of beat NIBBLES-1; that cycle it registers the final result and asserts out_valid.
REQ-021 SHALL give latency of 1 cycle from acceptance of the last beat to out_valid high.
REQ-022 SHALL hold out_valid and the result stable in HOLD until out_valid and out_ready are both high.
REQ-023 SHALL go HOLD->COLLECT on the out_valid and out_ready handshake; the cascade state resets to {0,1,0} in the same cycle.
REQ-024 SHALL drive in_ready = (state==COLLECT) or (state==HOLD and out_ready).
REQ-025 SHALL treat a beat accepted in the HOLD-release cycle as beat 0 of the next pair (zero-bubble streaming).
REQ-026 SHALL, on flush high in COLLECT, clear the counter and cascade state, produce no result, and ignore in_valid that cycle.
REQ-027 SHALL ignore flush in HOLD; the pending result is not lost.
REQ-028 SHALL drive out_gt/out_eq/out_lt to 0 when out_valid is low.
REQ-029 SHALL assert out_busy when state==COLLECT and counter != 0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state=COLLECT, counter=0, cascade={0,1,0}, out_valid=0, out_gt=out_eq=out_lt=0, out_busy=0.
REQ-031 SHALL drive in_ready high in the first cycle after rst_n deasserts.
REQ-032 SHALL discard any partial pair when reset is asserted mid-pair; no result is produced for that pair.

Verification
REQ-033 Unsigned, NIBBLES=4: A=0x1234, B=0x1235, one beat per cycle -> 1 cycle after last beat, out_valid=1, lt=1, gt=0, eq=0.
REQ-034 SIGNED=1: A=0x8000, B=0x0001 -> lt=1; the same operands with SIGNED=0 -> gt=1.
REQ-035 Early decision: A=0xF000, B=0x0FFF -> gt=1 set on beat 0 and unchanged by beats 1..3; A=B=0xABCD -> eq=1.
REQ-036 Backpressure: out_ready held low 5 cycles -> result stable, in_ready=0; out_ready=1 with the next beat 0 presented -> pair accepted with no bubble.
REQ-037 flush after 2 beats, then A=0x0002, B=0x0001 -> exactly one result, gt=1; rst_n pulsed low after 3 beats -> all outputs 0, next full pair compares correctly.

Source files
------------

// File: rtl/nibble_cascade_comparator.sv
// Serial magnitude comparator: two operands arrive one nibble pair per beat,
// most significant nibble first. The first unequal nibble decides the result;
// the remaining beats of that pair are still consumed but do not alter it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting nibble pairs, cascade state being built
// HOLD    | final result presented on out_*, waiting for out_ready
module nibble_cascade_comparator #(
    parameter int NIBBLES = 4,
    parameter bit SIGNED  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_gt,
    output logic       out_eq,
    output logic       out_lt,
    output logic       out_busy
);

    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gt_q, eq_q, lt_q;
    logic          gt_d, eq_d, lt_d;
    logic          accept;
    logic [3:0]    a_adj, b_adj;

    assign in_ready  = (state_q == COLLECT) || (state_q == HOLD && out_ready);
    assign accept    = in_valid && in_ready && !(flush && state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_gt    = out_valid && gt_q;
    assign out_eq    = out_valid && eq_q;
    assign out_lt    = out_valid && lt_q;
    assign out_busy  = (state_q == COLLECT) && (cnt_q != '0);

    // Flipping the sign bit of the top nibble maps two's-complement order onto
    // unsigned order, so the rest of the cascade stays a plain unsigned compare.
    always_comb begin
        a_adj = in_a;
        b_adj = in_b;
        if (SIGNED && cnt_q == '0) begin
            a_adj[3] = ~in_a[3];
            b_adj[3] = ~in_b[3];
        end
    end

    // Next state, beat counter and cascade update.
    always_comb begin
        logic base_gt, base_eq, base_lt;
        state_d = state_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        base_gt = gt_q;
        base_eq = eq_q;
        base_lt = lt_q;

        case (state_q)
            COLLECT: begin
                if (flush) begin
                    cnt_d = '0;
                    gt_d  = 1'b0;
                    eq_d  = 1'b1;
                    lt_d  = 1'b0;
                end else if (accept) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    base_gt = 1'b0;
                    base_eq = 1'b1;
                    base_lt = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    // A beat taken in the release cycle is beat 0 of the next
                    // pair; NIBBLES >= 2 so it can never also be the last beat.
                    if (accept) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        if (accept && base_eq) begin
            gt_d = (a_adj > b_adj);
            lt_d = (a_adj < b_adj);
            eq_d = (a_adj == b_adj);
        end else if (accept) begin
            gt_d = base_gt;
            eq_d = base_eq;
            lt_d = base_lt;
        end
    end

    // State, counter and cascade registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

endmodule
